// File: rtl/mul_div_arbiter_pkg.sv
// Shared types for the mul/div issue arbiter: ROB index, request record,
// in-flight counter type, output-stage state and parameter defaults.
package mul_div_arbiter_pkg;

  localparam int ROB_W_DEF        = 4;
  localparam int PAYLOAD_W_DEF    = 256;
  localparam int MAX_INFLIGHT_DEF = 1;

  typedef logic [ROB_W_DEF-1:0] rob_idx_t;
  typedef logic [1:0]           cnt_t;

  typedef struct packed {
    rob_idx_t                 rob;
    logic [PAYLOAD_W_DEF-1:0] payload;
  } md_req_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/mul_div_arbiter_if.sv
// Unit-side link of the arbiter: held operation toward the mul/div unit and
// the unit's allowin / completion pulses back.
interface mul_div_arbiter_if
  import mul_div_arbiter_pkg::*;
#(
  parameter int ROB_W     = ROB_W_DEF,
  parameter int PAYLOAD_W = PAYLOAD_W_DEF
);
  logic                 out_valid;
  logic [PAYLOAD_W-1:0] out_payload;
  logic [ROB_W-1:0]     out_rob;
  logic                 unit_allowin;
  logic                 unit_done;

  modport master (
    output out_valid, out_payload, out_rob,
    input  unit_allowin, unit_done
  );

  modport slave (
    input  out_valid, out_payload, out_rob,
    output unit_allowin, unit_done
  );
endinterface

// File: rtl/mul_div_arbiter_age_select.sv
// Combinational oldest-first selector: picks the valid request with the smallest
// distance from the ROB head; ties go to the lower index.
module mul_div_age_select #(
  parameter int NUM_REQ = 2,
  parameter int ROB_W   = 4
) (
  input  logic [NUM_REQ-1:0]       valid_i,
  input  logic [NUM_REQ*ROB_W-1:0] rob_i,
  input  logic [ROB_W-1:0]         head_i,
  output logic [NUM_REQ-1:0]       onehot_o,
  output logic                     found_o
);

  logic [ROB_W-1:0] age;
  logic [ROB_W-1:0] best_age;

  always_comb begin
    onehot_o = '0;
    found_o  = 1'b0;
    age      = '0;
    best_age = '1;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Modular subtraction gives distance from head even across wrap.
      age = rob_i[i*ROB_W +: ROB_W] - head_i;
      if (valid_i[i] && (!found_o || age < best_age)) begin
        found_o     = 1'b1;
        best_age    = age;
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_div_arbiter.sv
// Arbitrates NUM_REQ issue-side mul/div requests into a one-entry output stage
// and limits operations outstanding in the unit with a credit counter.
module mul_div_arbiter
  import mul_div_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int ROB_W        = ROB_W_DEF,
  parameter int PAYLOAD_W    = PAYLOAD_W_DEF,
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         flush,
  input  logic [ROB_W-1:0]             rob_head,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*ROB_W-1:0]     req_rob,
  input  logic [NUM_REQ*PAYLOAD_W-1:0] req_payload,
  output logic [NUM_REQ-1:0]           req_ready,
  mul_div_arbiter_if.master            unit_if,
  output cnt_t                         inflight,
  output logic                         arb_busy
);

  out_state_t           state_q, state_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic [ROB_W-1:0]     rob_q, rob_d;
  cnt_t                 inflight_q, inflight_d;

  logic [NUM_REQ-1:0]   win_oh;
  logic                 win_found;
  logic [PAYLOAD_W-1:0] win_payload;
  logic [ROB_W-1:0]     win_rob;
  logic                 credit_ok, accept, load, done_ok;

  mul_div_age_select #(.NUM_REQ(NUM_REQ), .ROB_W(ROB_W)) u_age_select (
    .valid_i  (req_valid),
    .rob_i    (req_rob),
    .head_i   (rob_head),
    .onehot_o (win_oh),
    .found_o  (win_found)
  );

  always_comb begin
    win_payload = '0;
    win_rob     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) begin
        win_payload = req_payload[i*PAYLOAD_W +: PAYLOAD_W];
        win_rob     = req_rob[i*ROB_W +: ROB_W];
      end
    end
  end

  assign credit_ok = (inflight_q < cnt_t'(MAX_INFLIGHT));
  assign accept    = (state_q == OUT_FULL) && unit_if.unit_allowin && credit_ok;
  assign load      = !flush && win_found && ((state_q == OUT_EMPTY) || accept);
  // A completion with nothing outstanding (e.g. after a flush) is stale.
  assign done_ok   = unit_if.unit_done && (inflight_q != '0);

  always_comb begin
    state_d    = state_q;
    payload_d  = payload_q;
    rob_d      = rob_q;
    inflight_d = inflight_q;
    if (flush) begin
      state_d    = OUT_EMPTY;
      inflight_d = '0;
    end else begin
      if (load) begin
        state_d   = OUT_FULL;
        payload_d = win_payload;
        rob_d     = win_rob;
      end else if (accept) begin
        state_d = OUT_EMPTY;
      end
      if (accept && !done_ok) inflight_d = inflight_q + 2'd1;
      else if (!accept && done_ok) inflight_d = inflight_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= OUT_EMPTY;
      payload_q  <= '0;
      rob_q      <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      payload_q  <= payload_d;
      rob_q      <= rob_d;
      inflight_q <= inflight_d;
    end
  end

  assign req_ready           = load ? win_oh : '0;
  assign unit_if.out_valid   = (state_q == OUT_FULL) && credit_ok;
  assign unit_if.out_payload = payload_q;
  assign unit_if.out_rob     = rob_q;
  assign inflight            = inflight_q;
  assign arb_busy            = (state_q == OUT_FULL) || (inflight_q != '0);

endmodule

// File: tb/tb_mul_div_arbiter.sv
// Directed vectors, corner sequences and a randomized run against an
// age-ordered reference model of the mul/div arbiter.
module tb_mul_div_arbiter;

  logic         clk = 1'b0;
  logic         resetn, flush;
  logic [3:0]   rob_head;
  logic [1:0]   req_valid;
  logic [3:0]   rob0, rob1;
  logic [255:0] pay0, pay1;
  logic [1:0]   req_ready;
  logic [1:0]   inflight;
  logic         arb_busy;
  logic [7:0]   req_rob;
  logic [511:0] req_payload;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign req_rob     = {rob1, rob0};
  assign req_payload = {pay1, pay0};

  mul_div_arbiter_if #(.ROB_W(4), .PAYLOAD_W(256)) uif ();

  mul_div_arbiter #(.NUM_REQ(2), .ROB_W(4), .PAYLOAD_W(256), .MAX_INFLIGHT(1)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .flush       (flush),
    .rob_head    (rob_head),
    .req_valid   (req_valid),
    .req_rob     (req_rob),
    .req_payload (req_payload),
    .req_ready   (req_ready),
    .unit_if     (uif),
    .inflight    (inflight),
    .arb_busy    (arb_busy)
  );

  typedef struct {
    logic [3:0] head;
    logic [1:0] vld;
    logic [3:0] r0;
    logic [3:0] r1;
    logic [1:0] rdy;
    logic [3:0] orob;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference model state
  bit           m_full;
  logic [3:0]   m_rob;
  logic [255:0] m_pay;
  int           m_cnt;

  task automatic model_cycle();
    bit   credit, ovld, acc, ld;
    int   w, best, a;
    logic [1:0] e_rdy;
    logic [3:0] robs[2];
    logic [255:0] pays[2];
    robs[0] = rob0; robs[1] = rob1;
    pays[0] = pay0; pays[1] = pay1;
    credit = (m_cnt < 1);
    ovld   = m_full && credit;
    acc    = ovld && uif.unit_allowin;
    w = -1; best = 16;
    for (int i = 0; i < 2; i++) begin
      if (req_valid[i]) begin
        a = (int'(robs[i]) - int'(rob_head) + 16) % 16;
        if (a < best) begin best = a; w = i; end
      end
    end
    ld    = !flush && (w >= 0) && (!m_full || acc);
    e_rdy = ld ? (2'b01 << w) : 2'b00;
    if (resetn) chk("rnd_ready", 256'(req_ready), 256'(e_rdy));
    chk("rnd_out_valid", 256'(uif.out_valid), 256'(ovld));
    chk("rnd_out_rob", 256'(uif.out_rob), 256'(m_rob));
    chk("rnd_out_payload", uif.out_payload, m_pay);
    chk("rnd_inflight", 256'(inflight), 256'(m_cnt));
    chk("rnd_busy", 256'(arb_busy), 256'(m_full || m_cnt != 0));
    if (!resetn) begin
      m_full = 0; m_rob = '0; m_pay = '0; m_cnt = 0;
    end else if (flush) begin
      m_full = 0; m_cnt = 0;
    end else begin
      if (ld) begin
        m_full = 1; m_rob = robs[w]; m_pay = pays[w];
      end else if (acc) begin
        m_full = 0;
      end
      m_cnt = m_cnt + (acc ? 1 : 0) - ((uif.unit_done && m_cnt > 0) ? 1 : 0);
    end
  endtask

  initial begin
    logic [255:0] pa, pb;
    tbl[0] = '{head: 4'd14, vld: 2'b11, r0: 4'd2, r1: 4'd15, rdy: 2'b10, orob: 4'd15};
    tbl[1] = '{head: 4'd0,  vld: 2'b01, r0: 4'd5, r1: 4'd9,  rdy: 2'b01, orob: 4'd5};
    tbl[2] = '{head: 4'd0,  vld: 2'b11, r0: 4'd5, r1: 4'd5,  rdy: 2'b01, orob: 4'd5};
    tbl[3] = '{head: 4'd3,  vld: 2'b11, r0: 4'd2, r1: 4'd3,  rdy: 2'b10, orob: 4'd3};
    tbl[4] = '{head: 4'd8,  vld: 2'b10, r0: 4'd8, r1: 4'd7,  rdy: 2'b10, orob: 4'd7};
    tbl[5] = '{head: 4'd8,  vld: 2'b11, r0: 4'd9, r1: 4'd12, rdy: 2'b01, orob: 4'd9};

    resetn = 0; flush = 0; rob_head = 0; req_valid = 0;
    rob0 = 0; rob1 = 0; pay0 = 0; pay1 = 0;
    uif.unit_allowin = 0; uif.unit_done = 0;
    repeat (2) @(negedge clk);
    resetn = 1;
    #1;
    chk("rst_out_valid", 256'(uif.out_valid), 256'(0));
    chk("rst_out_payload", uif.out_payload, 256'(0));
    chk("rst_out_rob", 256'(uif.out_rob), 256'(0));
    chk("rst_inflight", 256'(inflight), 256'(0));
    chk("rst_ready", 256'(req_ready), 256'(0));
    chk("rst_busy", 256'(arb_busy), 256'(0));

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rob_head = tbl[i].head; req_valid = tbl[i].vld;
      rob0 = tbl[i].r0; rob1 = tbl[i].r1;
      pay0 = rnd256(); pay1 = rnd256();
      #1 chk("vec_ready", 256'(req_ready), 256'(tbl[i].rdy));
      @(negedge clk);
      req_valid = 0;
      #1;
      chk("vec_out_valid", 256'(uif.out_valid), 256'(1));
      chk("vec_out_rob", 256'(uif.out_rob), 256'(tbl[i].orob));
      chk("vec_out_payload", uif.out_payload, tbl[i].rdy[1] ? pay1 : pay0);
      flush = 1;
      @(negedge clk);
      flush = 0;
      #1 chk("vec_flushed", 256'(uif.out_valid), 256'(0));
    end

    // Hold while the unit stalls, then accept with same-cycle reload
    @(negedge clk);
    rob_head = 0; req_valid = 2'b01; rob0 = 4'd1; pa = rnd256(); pay0 = pa;
    @(negedge clk);
    req_valid = 2'b10; rob1 = 4'd2;
    for (int k = 0; k < 5; k++) begin
      pay1 = rnd256();
      #1;
      chk("hold_ready", 256'(req_ready), 256'(0));
      chk("hold_payload", uif.out_payload, pa);
      chk("hold_valid", 256'(uif.out_valid), 256'(1));
      @(negedge clk);
    end
    pb = rnd256(); pay1 = pb; uif.unit_allowin = 1;
    #1 chk("b2b_ready", 256'(req_ready), 256'(2'b10));
    @(negedge clk);
    req_valid = 0;
    #1;
    chk("credit_payload", uif.out_payload, pb);
    chk("credit_rob", 256'(uif.out_rob), 256'(2));
    chk("credit_inflight", 256'(inflight), 256'(1));
    chk("credit_gated_valid", 256'(uif.out_valid), 256'(0));
    chk("credit_busy", 256'(arb_busy), 256'(1));
    @(negedge clk);
    #1 chk("credit_stall_inflight", 256'(inflight), 256'(1));
    uif.unit_done = 1;
    @(negedge clk);
    uif.unit_done = 0;
    #1;
    chk("done_inflight", 256'(inflight), 256'(0));
    chk("done_valid", 256'(uif.out_valid), 256'(1));
    @(negedge clk);
    #1;
    chk("b_accept_inflight", 256'(inflight), 256'(1));
    chk("b_accept_valid", 256'(uif.out_valid), 256'(0));

    // Flush while FULL with one op in flight
    uif.unit_allowin = 0; req_valid = 2'b01; rob0 = 4'd4; pay0 = rnd256();
    @(negedge clk);
    #1;
    chk("pre_flush_busy", 256'(arb_busy), 256'(1));
    chk("pre_flush_inflight", 256'(inflight), 256'(1));
    flush = 1;
    #1 chk("flush_ready", 256'(req_ready), 256'(0));
    @(negedge clk);
    flush = 0; req_valid = 0;
    #1;
    chk("flush_valid", 256'(uif.out_valid), 256'(0));
    chk("flush_inflight", 256'(inflight), 256'(0));
    chk("flush_busy", 256'(arb_busy), 256'(0));
    uif.unit_done = 1;
    @(negedge clk);
    uif.unit_done = 0;
    #1 chk("stray_done_inflight", 256'(inflight), 256'(0));

    // Reset in the middle of an operation
    req_valid = 2'b01; rob0 = 4'd6; pay0 = rnd256();
    @(negedge clk);
    req_valid = 2'b10; rob1 = 4'd7; pay1 = rnd256(); uif.unit_allowin = 1;
    @(negedge clk);
    req_valid = 0; uif.unit_allowin = 0;
    #1 chk("pre_rst_inflight", 256'(inflight), 256'(1));
    resetn = 0;
    @(negedge clk);
    resetn = 1;
    #1;
    chk("mid_rst_valid", 256'(uif.out_valid), 256'(0));
    chk("mid_rst_payload", uif.out_payload, 256'(0));
    chk("mid_rst_inflight", 256'(inflight), 256'(0));
    chk("mid_rst_busy", 256'(arb_busy), 256'(0));

    // Randomized run against the model
    m_full = 0; m_rob = '0; m_pay = '0; m_cnt = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rob_head  = 4'($urandom);
      req_valid = 2'($urandom);
      rob0 = 4'($urandom); rob1 = 4'($urandom);
      pay0 = rnd256(); pay1 = rnd256();
      uif.unit_allowin = 1'($urandom);
      uif.unit_done    = ($urandom_range(0, 3) == 0);
      flush            = ($urandom_range(0, 31) == 0);
      resetn           = ($urandom_range(0, 63) != 0);
      #1 model_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
